onoff_cmd_gen: RTL and testbench

//   Upstream command stage for the ON/OFF state machine. Converts two raw push-buttons (btn_on, btn_off)

---
 rtl/onoff_cmd_gen.sv | 132 +++++++++++++
 tb/tb_onoff_cmd_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/onoff_cmd_gen.sv
// Two-button command front end: synchronise, debounce and edge-detect btn_on/btn_off
// into single-cycle j/k requests, with "off" taking priority over "on".
module onoff_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_on,
    input  logic btn_off,
    output logic j,
    output logic k,
    output logic on_stable,
    output logic off_stable
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM_PRS = 2'd1;
    localparam logic [1:0] PRESSED = 2'd2;
    localparam logic [1:0] ARM_REL = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Bit 0 carries the "on" button, bit 1 the "off" button.
    logic [1:0] raw;
    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] press;
    logic [1:0] held_nxt;
    logic       off_held;

    assign raw = {btn_off, btn_on};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0]       state;
        logic [1:0]       state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             evt;

        always_comb begin
            // NOTE: every output of this block gets a default first, so no latch is inferred.
            state_nxt = state;
            cnt_nxt   = cnt;
            evt       = 1'b0;
            case (state)
                IDLE: begin
                    if (sync[b]) begin
                        state_nxt = ARM_PRS;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                ARM_PRS: begin
                    if (!sync[b]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        evt       = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync[b]) begin
                        state_nxt = ARM_REL;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                ARM_REL: begin
                    if (sync[b]) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        assign press[b]    = evt;
        assign held_nxt[b] = (state_nxt == PRESSED) || (state_nxt == ARM_REL);
    end

    // An "on" press is dropped while "off" is held or accepted on the same edge.
    assign off_held = (g_btn[1].state == PRESSED) || (g_btn[1].state == ARM_REL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j          <= 1'b0;
            k          <= 1'b0;
            on_stable  <= 1'b0;
            off_stable <= 1'b0;
        end else begin
            j          <= press[0] & ~press[1] & ~off_held;
            k          <= press[1];
            on_stable  <= held_nxt[0];
            off_stable <= held_nxt[1];
        end
    end

endmodule

// File: tb/tb_onoff_cmd_gen.sv
// Bench for onoff_cmd_gen: table-driven button patterns plus hand-written reset/bounce
// sequences; expected j/k pulses are queued with their edge number and matched as they appear.
module tb_onoff_cmd_gen;

    logic clk = 1'b0;
    logic rst;
    logic btn_on;
    logic btn_off;
    logic j;
    logic k;
    logic on_stable;
    logic off_stable;

    always #5 clk = ~clk;

    onoff_cmd_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_on    (btn_on),
        .btn_off   (btn_off),
        .j         (j),
        .k         (k),
        .on_stable (on_stable),
        .off_stable(off_stable)
    );

    typedef struct {
        int edge_no;
        bit is_k;
    } exp_t;

    typedef struct {
        string     name;
        bit [31:0] on_pat;   // bit i = btn_on level driven before relative edge i+1
        bit [31:0] off_pat;
        int        j_at;     // relative edge after which j is high, 0 = never
        int        k_at;
        bit        on_st;
        bit        off_st;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_pulse(input bit is_k, input int edge_no);
        exp_t e;
        e.edge_no = edge_no;
        e.is_k    = is_k;
        sb.push_back(e);
    endtask

    // Every j/k pulse must match the oldest queued expectation, in edge and in kind.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        if (j === 1'b1 || k === 1'b1) begin
            check("j_k_exclusive", 32'(j & k), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got j=%0b k=%0b at edge %0d, expected none",
                         j, k, edge_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_edge", edge_cnt, mon_e.edge_no);
                check("pulse_is_k", 32'(k), 32'(mon_e.is_k));
            end
        end
    end

    task automatic sb_drained(input string name);
        check({name, "_sb_empty"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        btn_on  = 1'b0;
        btn_off = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, j, k, on_stable, off_stable}, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        btn_on  = 1'b0;
        btn_off = 1'b0;

        vecs[0]  = '{"on_held",        32'hFFFF_FFFF, 32'h0000_0000, 7, 0,  1'b1, 1'b0};
        vecs[1]  = '{"on_pulse3",      32'h0000_0007, 32'h0000_0000, 0, 0,  1'b0, 1'b0};
        vecs[2]  = '{"on_pulse4",      32'h0000_000F, 32'h0000_0000, 0, 0,  1'b0, 1'b0};
        vecs[3]  = '{"on_pulse5",      32'h0000_001F, 32'h0000_0000, 7, 0,  1'b0, 1'b0};
        vecs[4]  = '{"off_held",       32'h0000_0000, 32'hFFFF_FFFF, 0, 7,  1'b0, 1'b1};
        vecs[5]  = '{"both_rise",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 7,  1'b1, 1'b1};
        vecs[6]  = '{"on_then_off",    32'hFFFF_FFFF, 32'hFFFF_FC00, 7, 17, 1'b1, 1'b1};
        vecs[7]  = '{"off_then_on",    32'hFFFF_FC00, 32'hFFFF_FFFF, 0, 7,  1'b1, 1'b1};
        vecs[8]  = '{"on_rel_glitch",  32'hFFFF_EFFF, 32'h0000_0000, 7, 0,  1'b1, 1'b0};
        vecs[9]  = '{"off_one_later",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 8,  1'b1, 1'b1};
        vecs[10] = '{"on_one_later",   32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 7,  1'b1, 1'b1};

        for (int v = 0; v < 11; v++) begin
            int base;
            do_reset();
            base = edge_cnt;
            if (vecs[v].j_at > 0 && vecs[v].k_at > 0 && vecs[v].k_at < vecs[v].j_at) begin
                expect_pulse(1'b1, base + vecs[v].k_at);
                expect_pulse(1'b0, base + vecs[v].j_at);
            end else begin
                if (vecs[v].j_at > 0) expect_pulse(1'b0, base + vecs[v].j_at);
                if (vecs[v].k_at > 0) expect_pulse(1'b1, base + vecs[v].k_at);
            end
            for (int i = 0; i < 40; i++) begin
                btn_on  = (i < 32) ? vecs[v].on_pat[i]  : vecs[v].on_pat[31];
                btn_off = (i < 32) ? vecs[v].off_pat[i] : vecs[v].off_pat[31];
                @(negedge clk);
            end
            sb_drained(vecs[v].name);
            check({vecs[v].name, "_on_stable"},  32'(on_stable),  32'(vecs[v].on_st));
            check({vecs[v].name, "_off_stable"}, 32'(off_stable), 32'(vecs[v].off_st));
        end

        // Button held through reset is debounced from scratch after release.
        rst     = 1'b0;
        btn_on  = 1'b1;
        btn_off = 1'b0;
        repeat (3) @(negedge clk);
        check("held_reset_outputs", {28'd0, j, k, on_stable, off_stable}, 32'd0);
        rst = 1'b1;
        expect_pulse(1'b0, edge_cnt + 7);
        repeat (12) @(negedge clk);
        sb_drained("held_reset");
        check("held_reset_on_stable", 32'(on_stable), 32'd1);

        // Off held, released, held again: two separate k pulses.
        do_reset();
        btn_off = 1'b1;
        expect_pulse(1'b1, edge_cnt + 7);
        repeat (20) @(negedge clk);
        btn_off = 1'b0;
        repeat (10) @(negedge clk);
        check("off_twice_released", 32'(off_stable), 32'd0);
        btn_off = 1'b1;
        expect_pulse(1'b1, edge_cnt + 7);
        repeat (12) @(negedge clk);
        sb_drained("off_twice");
        check("off_twice_off_stable", 32'(off_stable), 32'd1);

        // On held, then off bounces 1-0-1-0 before settling high.
        do_reset();
        btn_on = 1'b1;
        expect_pulse(1'b0, edge_cnt + 7);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            btn_off = (i % 2 == 0);
            @(negedge clk);
        end
        btn_off = 1'b1;
        expect_pulse(1'b1, edge_cnt + 7);
        repeat (12) @(negedge clk);
        sb_drained("off_bounce");
        check("off_bounce_on_stable",  32'(on_stable),  32'd1);
        check("off_bounce_off_stable", 32'(off_stable), 32'd1);

        // Reset in the middle of the on-button debounce aborts it.
        do_reset();
        btn_on = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_reset_j",         32'(j),         32'd0);
        check("mid_reset_on_stable", 32'(on_stable), 32'd0);
        rst = 1'b1;
        expect_pulse(1'b0, edge_cnt + 7);
        repeat (12) @(negedge clk);
        sb_drained("mid_reset");
        check("mid_reset_on_after", 32'(on_stable), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
